// File: rtl/frame_sync.sv
// Serial frame synchroniser: hunts for SYNC_WORD, confirms it over VERIFY_HITS frames, then flywheels and emits payload bytes.
// Optional FRAME_SYNC_INV_EN: also accepts a bit-inverted stream and reports it on out_inv.
module frame_sync #(
    parameter logic [7:0]  SYNC_WORD     = 8'hB2,
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned VERIFY_HITS   = 2,
    parameter int unsigned MISS_LIMIT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       locked,
    output logic       frame_start,
    output logic       out_inv
);

    localparam int unsigned FRAME_BITS = 8 * (1 + PAYLOAD_BYTES);
    localparam int unsigned CW         = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] PAY_END  = CW'(8 * PAYLOAD_BYTES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

    state_t        state, state_next;
    logic [6:0]    sr;
    logic [7:0]    window;
    logic [CW-1:0] bit_cnt, cnt_next;
    logic [2:0]    hit_cnt, hit_next;
    logic [2:0]    miss_cnt, miss_next;
    logic          inv_next, start_next, valid_next, load_byte;
    logic          match_true, match_inv, hit, check_edge, byte_edge;

    assign window     = {sr, in_data};
    assign match_true = (window == SYNC_WORD);
`ifdef FRAME_SYNC_INV_EN
    assign match_inv  = (window == ~SYNC_WORD);
`else
    assign match_inv  = 1'b0;
`endif
    // Once synced, checks follow the polarity chosen at acquisition.
    assign hit        = (window == (SYNC_WORD ^ {8{out_inv}}));
    assign check_edge = (bit_cnt == LAST_BIT);
    assign byte_edge  = (bit_cnt[2:0] == 3'd7) && (bit_cnt < PAY_END);

    always_comb begin
        state_next = state;
        cnt_next   = check_edge ? '0 : bit_cnt + 1'b1;
        hit_next   = hit_cnt;
        miss_next  = miss_cnt;
        inv_next   = out_inv;
        start_next = 1'b0;
        valid_next = 1'b0;
        load_byte  = 1'b0;
        case (state)
            SEARCH: begin
                if (match_true || match_inv) begin
                    cnt_next   = '0;
                    hit_next   = 3'd1;
                    miss_next  = '0;
                    inv_next   = match_inv;
                    state_next = (VERIFY_HITS == 1) ? LOCK : VERIFY;
                end
            end
            VERIFY: begin
                if (check_edge) begin
                    if (hit) begin
                        hit_next = hit_cnt + 3'd1;
                        if (hit_next == 3'(VERIFY_HITS)) state_next = LOCK;
                    end else begin
                        state_next = SEARCH;
                        hit_next   = '0;
                        inv_next   = 1'b0;
                    end
                end
            end
            LOCK: begin
                if (byte_edge) begin
                    load_byte  = 1'b1;
                    valid_next = 1'b1;
                end
                if (check_edge) begin
                    if (hit) begin
                        miss_next  = '0;
                        start_next = 1'b1;
                    end else if (miss_cnt + 3'd1 == 3'(MISS_LIMIT)) begin
                        state_next = SEARCH;
                        miss_next  = '0;
                        hit_next   = '0;
                        inv_next   = 1'b0;
                    end else begin
                        miss_next = miss_cnt + 3'd1;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr          <= '0;
            bit_cnt     <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            out_inv     <= 1'b0;
        end else begin
            sr          <= window[6:0];
            bit_cnt     <= cnt_next;
            hit_cnt     <= hit_next;
            miss_cnt    <= miss_next;
            out_valid   <= valid_next;
            locked      <= (state_next == LOCK);
            frame_start <= start_next;
            out_inv     <= inv_next;
            if (load_byte) out_data <= window ^ {8{out_inv}};
        end
    end

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync: acquisition, flywheel/loss, reset, polarity and single-hit lock.
module tb_frame_sync;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_data = 1'b0;
    logic       in_data_b = 1'b0;
    logic [7:0] out_data, out_data_b;
    logic       out_valid, locked, frame_start, out_inv;
    logic       out_valid_b, locked_b, frame_start_b, out_inv_b;

    int n_total = 0;
    int n_bad   = 0;
    int n_valid = 0;
    int n_start = 0;

    logic [7:0] pay [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    frame_sync dut (
        .clk(clk), .reset(reset), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .locked(locked),
        .frame_start(frame_start), .out_inv(out_inv)
    );

    frame_sync #(.VERIFY_HITS(1)) dut_v1 (
        .clk(clk), .reset(reset), .in_data(in_data_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .locked(locked_b),
        .frame_start(frame_start_b), .out_inv(out_inv_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit alt);
        if (alt) in_data_b = b;
        else     in_data   = b;
        @(posedge clk);
        #1;
        if (out_valid)   n_valid++;
        if (frame_start) n_start++;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit alt);
        for (int i = 7; i >= 0; i--) send_bit(v[i], alt);
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] xr);
        send_byte(s, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(pay[k] ^ xr, 1'b0);
    endtask

    task automatic do_reset();
        in_data   = 1'b0;
        in_data_b = 1'b0;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        n_valid = 0;
        n_start = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with no clock edge yet: outputs must already be cleared.
        #2 reset = 1'b0;
        #1;
        check("rst_data",   32'(out_data),    32'h00);
        check("rst_valid",  32'(out_valid),   32'h0);
        check("rst_locked", 32'(locked),      32'h0);
        check("rst_start",  32'(frame_start), 32'h0);
        check("rst_inv",    32'(out_inv),     32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Scenario 1: three good frames
        send_frame(8'hB2, 8'h00);
        check("s1_f1_locked", 32'(locked), 32'h0);
        check("s1_f1_valid",  32'(n_valid), 32'd0);
        send_byte(8'hB2, 1'b0);
        check("s1_lock_rise", 32'(locked), 32'h1);
        check("s1_no_start",  32'(n_start), 32'd0);
        for (int k = 0; k < 4; k++) begin
            send_byte(pay[k], 1'b0);
            check("s1_f2_valid", 32'(out_valid), 32'h1);
            check("s1_f2_data",  32'(out_data),  32'(pay[k]));
        end
        check("s1_f2_count", 32'(n_valid), 32'd4);
        send_byte(8'hB2, 1'b0);
        check("s1_f3_start", 32'(frame_start), 32'h1);
        for (int k = 0; k < 4; k++) send_byte(pay[k], 1'b0);
        check("s1_start_cnt", 32'(n_start), 32'd1);
        check("s1_valid_cnt", 32'(n_valid), 32'd8);
        check("s1_hold",      32'(out_data), 32'h44);

        // Scenario 3: flywheel through two misses, lose lock on the third
        n_valid = 0;
        send_frame(8'h5A, 8'h00);
        send_frame(8'h5A, 8'h00);
        check("s3_two_miss_locked", 32'(locked), 32'h1);
        check("s3_two_miss_valid",  32'(n_valid), 32'd8);
        send_frame(8'hB2, 8'h00);
        check("s3_recover_start", 32'(n_start), 32'd2);
        send_frame(8'h5A, 8'h00);
        send_frame(8'h5A, 8'h00);
        check("s3_still_locked", 32'(locked), 32'h1);
        send_byte(8'h5A, 1'b0);
        check("s3_drop", 32'(locked), 32'h0);
        n_valid = 0;
        for (int k = 0; k < 4; k++) send_byte(pay[k], 1'b0);
        check("s3_no_valid", 32'(n_valid), 32'd0);
        check("s3_hold",     32'(out_data), 32'h44);

        // Scenario 2: single sync then no sync at the check edge
        do_reset();
        send_byte(8'hB2, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h0F, 1'b0);
        send_byte(8'h00, 1'b0);
        check("s2_locked", 32'(locked), 32'h0);
        send_frame(8'hB2, 8'h00);
        check("s2_locked2", 32'(locked), 32'h0);
        check("s2_valid",   32'(n_valid), 32'd0);
        send_byte(8'hB2, 1'b0);
        check("s2_research_lock", 32'(locked), 32'h1);

        // Scenario 4: asynchronous reset mid-byte while locked
        do_reset();
        send_frame(8'hB2, 8'h00);
        send_byte(8'hB2, 1'b0);
        send_byte(8'h11, 1'b0);
        check("s4_pre_data", 32'(out_data), 32'h11);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("s4_rst_data",   32'(out_data),    32'h00);
        check("s4_rst_valid",  32'(out_valid),   32'h0);
        check("s4_rst_locked", 32'(locked),      32'h0);
        check("s4_rst_start",  32'(frame_start), 32'h0);
        check("s4_rst_inv",    32'(out_inv),     32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        in_data = 1'b0;
        n_valid = 0;
        send_frame(8'hB2, 8'h00);
        check("s4_one_sync", 32'(locked), 32'h0);
        send_byte(8'hB2, 1'b0);
        check("s4_relock", 32'(locked), 32'h1);
        send_byte(8'h11, 1'b0);
        check("s4_relock_data", 32'(out_data), 32'h11);

        // Scenario 5: inverted stream
        do_reset();
        send_frame(8'h4D, 8'hFF);
`ifdef FRAME_SYNC_INV_EN
        check("s5_inv",     32'(out_inv), 32'h1);
        check("s5_not_yet", 32'(locked),  32'h0);
        send_byte(8'h4D, 1'b0);
        check("s5_lock", 32'(locked), 32'h1);
        for (int k = 0; k < 4; k++) begin
            send_byte(pay[k] ^ 8'hFF, 1'b0);
            check("s5_valid", 32'(out_valid), 32'h1);
            check("s5_data",  32'(out_data),  32'(pay[k]));
        end
`else
        send_frame(8'h4D, 8'hFF);
        send_frame(8'h4D, 8'hFF);
        check("s5_locked", 32'(locked),  32'h0);
        check("s5_valid",  32'(n_valid), 32'd0);
        check("s5_inv",    32'(out_inv), 32'h0);
`endif

        // Scenario 6: VERIFY_HITS = 1 locks straight from search
        do_reset();
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hB2 >> i), 1'b1);
        check("s6_before", 32'(locked_b), 32'h0);
        send_bit(1'b0, 1'b1);
        check("s6_lock", 32'(locked_b), 32'h1);
        send_byte(8'h11, 1'b1);
        check("s6_valid", 32'(out_valid_b), 32'h1);
        check("s6_data",  32'(out_data_b),  32'h11);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
